// File: rtl/sha_uart_pkg.sv
// sha_uart_pkg
// Shared constants and the FSM state type for the SHA-digest-to-UART return path.
//   DIGEST_BITS_DEFAULT : default digest width (SHA-256)
//   ASCII_CR / ASCII_LF : line terminator characters used by the hex-ASCII build
//   state_t             : IDLE / SEND, plus SEND_CR / SEND_LF used only when
//                         SHA_UART_HEX_ASCII_EN is defined
package sha_uart_pkg;

  localparam int DIGEST_BITS_DEFAULT = 256;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_SEND_CR = 2'd2;
  localparam logic [1:0] ST_SEND_LF = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SEND    = ST_SEND,
    SEND_CR = ST_SEND_CR,
    SEND_LF = ST_SEND_LF
  } state_t;

endpackage

// File: rtl/sha_digest_to_uart_buffer_hex_nibble_to_ascii.sv
// hex_nibble_to_ascii
// Combinational map of one 4-bit nibble to its lowercase hex ASCII character.
// Ports:
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9' (0x30..0x39) or 'a'..'f' (0x61..0x66)
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0x57 + 10 = 0x61 ('a'), so the letter range needs no separate subtract.
  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h57 + {4'h0, nibble});

endmodule

// File: rtl/sha_digest_to_uart_buffer.sv
// sha_digest_to_uart_buffer
// Latches a finished SHA digest on a one-cycle valid pulse and streams it,
// most significant byte first, to a UART transmitter over a valid/ready
// byte handshake.
// Build option: define SHA_UART_HEX_ASCII_EN to emit lowercase hex ASCII
// (two characters per byte, upper nibble first) followed by CR LF; when
// undefined, raw binary bytes are sent with no terminator.
// Ports:
//   clk, rst     : clock; asynchronous active-high reset
//   digest       : digest from the SHA core, sampled when digest_valid=1
//   digest_valid : one-cycle pulse; ignored while busy
//   busy         : high while a digest is being sent
//   tx_data      : byte/character to UART TX
//   tx_valid     : tx_data valid; a transfer happens on tx_valid & tx_ready
//   tx_ready     : UART TX accepts the byte
//   done         : one-cycle pulse after the final transfer
module sha_digest_to_uart_buffer
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_BITS = DIGEST_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   digest_valid,
  output logic                   busy,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   done
);

  localparam int NUM_BYTES = DIGEST_BITS / 8;
`ifdef SHA_UART_HEX_ASCII_EN
  localparam int NUM_XFERS = 2 * NUM_BYTES + 2;
`else
  localparam int NUM_XFERS = NUM_BYTES;
`endif
  localparam int CNT_W = $clog2(NUM_XFERS + 1);

  state_t                 state;
  logic [DIGEST_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]       count;   // transfers still outstanding
  logic                   xfer;

  assign xfer = tx_valid & tx_ready;

`ifdef SHA_UART_HEX_ASCII_EN
  logic       nibble_low;          // 0: upper nibble is on the wire, 1: lower
  logic [3:0] nibble;
  logic [7:0] nibble_ascii;

  assign nibble = nibble_low ? shift_reg[DIGEST_BITS-5 -: 4]
                             : shift_reg[DIGEST_BITS-1 -: 4];

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (nibble_ascii)
  );

  // Output character is a pure decode of registered state, so it is stable
  // for as long as the FSM waits on tx_ready.
  always_comb begin
    case (state)
      SEND:    tx_data = nibble_ascii;
      SEND_CR: tx_data = ASCII_CR;
      SEND_LF: tx_data = ASCII_LF;
      default: tx_data = 8'h00;
    endcase
  end
`else
  // The byte on the wire is always the top of the shift register; it reads
  // 0x00 in IDLE because the register is fully shifted out (or reset).
  assign tx_data = shift_reg[DIGEST_BITS-1 -: 8];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      busy      <= 1'b0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
`ifdef SHA_UART_HEX_ASCII_EN
      nibble_low <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (digest_valid) begin
            shift_reg <= digest;
            count     <= CNT_W'(NUM_XFERS);
            busy      <= 1'b1;
            tx_valid  <= 1'b1;
            state     <= SEND;
`ifdef SHA_UART_HEX_ASCII_EN
            nibble_low <= 1'b0;
`endif
          end
        end

        SEND: begin
          if (xfer) begin
            count <= count - 1'b1;
`ifdef SHA_UART_HEX_ASCII_EN
            nibble_low <= ~nibble_low;
            // The byte is consumed only once its lower nibble has gone out.
            if (nibble_low) begin
              shift_reg <= shift_reg << 8;
              // Three left = this character plus CR and LF.
              if (count == CNT_W'(3)) begin
                state <= SEND_CR;
              end
            end
`else
            shift_reg <= shift_reg << 8;
            if (count == CNT_W'(1)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_valid <= 1'b0;
              done     <= 1'b1;
            end
`endif
          end
        end

`ifdef SHA_UART_HEX_ASCII_EN
        SEND_CR: begin
          if (xfer) begin
            count <= count - 1'b1;
            state <= SEND_LF;
          end
        end

        SEND_LF: begin
          if (xfer) begin
            count    <= count - 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            done     <= 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_digest_to_uart_buffer.sv
// tb_sha_digest_to_uart_buffer
// Scoreboard bench: each scenario pushes the expected byte stream when it
// pulses digest_valid; a negedge monitor pops and compares every transfer
// and checks that tx_valid/tx_data hold steady while stalled.
module tb_sha_digest_to_uart_buffer;

  localparam int DB = 256;
  localparam int NB = DB / 8;
`ifdef SHA_UART_HEX_ASCII_EN
  localparam int NT = 2 * NB + 2;
`else
  localparam int NT = NB;
`endif

  localparam logic [DB-1:0] ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DB-1:0] ALT  = 256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [DB-1:0] ONES = {DB{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] digest = '0;
  logic          digest_valid = 1'b0;
  logic          busy;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rcnt = 0;
  int xfer_count = 0;
  int last_xfer_cyc = 0;

  logic [7:0] sb[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  sha_digest_to_uart_buffer #(.DIGEST_BITS(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // tx_ready pattern: mode 0 = always ready, mode 1 = ready one cycle in three.
  always begin
    @(posedge clk);
    #1;
    rcnt = rcnt + 1;
    tx_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
  end

  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%02h, required tx_valid=1 tx_data=%02h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h with empty scoreboard", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL byte_%0d: got %02h, required %02h", xfer_count, tx_data, exp_b);
          end else begin
            $display("xfer %0d: tx_data=%02h", xfer_count, tx_data);
          end
        end
        xfer_count++;
        last_xfer_cyc = cyc;
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
  endfunction

  function automatic logic [7:0] first_char(input logic [DB-1:0] d);
`ifdef SHA_UART_HEX_ASCII_EN
    return hexc(d[DB-1 -: 4]);
`else
    return d[DB-1 -: 8];
`endif
  endfunction

  task automatic push_expected(input logic [DB-1:0] d);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      b = d[DB-1-8*i -: 8];
`ifdef SHA_UART_HEX_ASCII_EN
      sb.push_back(hexc(b[7:4]));
      sb.push_back(hexc(b[3:0]));
`else
      sb.push_back(b);
`endif
    end
`ifdef SHA_UART_HEX_ASCII_EN
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
`endif
  endtask

  // Drives a one-cycle digest_valid; returns the cycle number of the
  // sampling edge, positioned just after that edge.
  task automatic pulse_digest(input logic [DB-1:0] d, output int k);
    @(posedge clk);
    #1;
    digest = d;
    digest_valid = 1'b1;
    @(posedge clk);
    #1;
    digest_valid = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int busy_low);
    seen = 1'b0;
    busy_low = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        return;
      end
      if (busy !== 1'b1) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", tx_data); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int k;
    bit seen;
    int bl;
    ready_mode = 0;
    push_expected(ABC);
    pulse_digest(ABC, k);
    checks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== first_char(ABC)) begin
      errors++;
      $display("FAIL stream_first: tx_valid=%b busy=%b tx_data=%02h, required 1 1 %02h",
               tx_valid, busy, tx_data, first_char(ABC));
    end
    wait_done(NT + 20, seen, bl);
    checks++;
    if (!seen) begin errors++; $display("FAIL stream_done_timeout: no done within %0d cycles", NT + 20); end
    checks++;
    if (cyc !== k + NT) begin errors++; $display("FAIL stream_done_cycle: done at %0d, required %0d", cyc, k + NT); end
    checks++;
    if (cyc !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL stream_done_after_last: done at %0d, required %0d", cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stream_left: %0d bytes missing, required 0", sb.size()); end
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle: busy=%b tx_valid=%b, required 0 0", busy, tx_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse: done=%b, required 0", done); end
  endtask

  task automatic test_backpressure();
    int k;
    bit seen;
    int bl;
    ready_mode = 1;
    push_expected(ABC);
    pulse_digest(ABC, k);
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b, required 1", tx_valid); end
    wait_done(3 * NT + 20, seen, bl);
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_done_timeout: no done within %0d cycles", 3 * NT + 20); end
    checks++;
    if (cyc !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL bp_done_after_last: done at %0d, required %0d", cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_left: %0d bytes missing, required 0", sb.size()); end
    ready_mode = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_midstream_ignore();
    int k;
    bit seen;
    int bl;
    ready_mode = 0;
    push_expected(ABC);
    pulse_digest(ABC, k);
    repeat (5) @(posedge clk);
    #1;
    digest = ONES;
    digest_valid = 1'b1;
    @(posedge clk);
    #1;
    digest_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b, required 1", busy); end
    wait_done(NT + 20, seen, bl);
    checks++;
    if (!seen) begin errors++; $display("FAIL ignore_done_timeout: no done within %0d cycles", NT + 20); end
    checks++;
    if (bl != 0) begin errors++; $display("FAIL ignore_busy_drop: busy low %0d cycles, required 0", bl); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL ignore_left: %0d bytes missing, required 0", sb.size()); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_restart: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_reset_midstream();
    int k;
    bit seen;
    int bl;
    ready_mode = 0;
    push_expected(ABC);
    xfer_count = 0;
    pulse_digest(ABC, k);
    for (int i = 0; i < 50 && xfer_count < 10; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (xfer_count != 10) begin errors++; $display("FAIL rstm_count: %0d transfers, required 10", xfer_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstm_async: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstm_quiet: tx_valid=%b, required 0", tx_valid); end
    push_expected(ABC);
    pulse_digest(ABC, k);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== first_char(ABC)) begin
      errors++;
      $display("FAIL rstm_restart: tx_valid=%b tx_data=%02h, required 1 %02h", tx_valid, tx_data, first_char(ABC));
    end
    wait_done(NT + 20, seen, bl);
    checks++;
    if (!seen) begin errors++; $display("FAIL rstm_done_timeout: no done within %0d cycles", NT + 20); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rstm_left: %0d bytes missing, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    int bl;
    ready_mode = 0;
    push_expected(ABC);
    push_expected(ALT);
    pulse_digest(ABC, k);
    seen = 1'b0;
    for (int i = 0; i < NT + 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        digest = ALT;
        digest_valid = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_first_done_timeout: no done within %0d cycles", NT + 20); end
    @(posedge clk);
    #1;
    digest_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== first_char(ALT) || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_start: tx_valid=%b tx_data=%02h done=%b, required 1 %02h 0",
               tx_valid, tx_data, done, first_char(ALT));
    end
    wait_done(NT + 20, seen, bl);
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_second_done_timeout: no done within %0d cycles", NT + 20); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_left: %0d bytes missing, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_midstream_ignore();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha_digest_to_uart_buffer.md
Name: sha_digest_to_uart_buffer

Overview:
Serializes a finished SHA digest into a byte stream for the UART transmitter, the return path of the UART-to-SHA input buffer. Latches the digest on a one-cycle valid pulse, then emits it MSB byte first over a valid/ready byte handshake to the UART TX. Sits between the SHA core output and the UART TX. Optionally emits lowercase hex ASCII terminated by CR LF.

Parameters:
DIGEST_BITS, 256, digest width; must be a multiple of 8 (256 for SHA-256, 160 for SHA-1).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
digest  input  DIGEST_BITS  digest from SHA core, sampled only when digest_valid=1
digest_valid  input  1  one-cycle pulse: digest is valid
busy  output  1  high while a digest is being sent; new digest_valid ignored
tx_data  output  8  byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX accepts byte; transfer when tx_valid & tx_ready
done  output  1  one-cycle pulse after final byte transferred

Behaviour:
- Reset (async): state IDLE; busy=0, tx_valid=0, tx_data=8'h00, done=0; shift register and counter cleared. Reset mid-stream abandons the digest; no further bytes are emitted.
- States: IDLE, SEND. Optional-feature states: SEND_CR, SEND_LF.
- IDLE: on digest_valid=1, latch digest into shift register, load byte counter with DIGEST_BITS/8, go to SEND. Next cycle: busy=1, tx_valid=1, tx_data=digest[DIGEST_BITS-1 -: 8]. Latency from digest_valid to first tx_valid: 1 cycle.
- SEND: tx_valid held at 1. tx_data is stable while tx_valid & !tx_ready. tx_valid never drops without a transfer, except on reset.
- On transfer: shift register left 8, counter-1. If more bytes remain, the next byte is presented the following cycle. With tx_ready tied high, throughput is 1 byte per cycle.
- On transfer of the last byte: next cycle tx_valid=0, busy=0, done=1 for one cycle, state IDLE.
- digest_valid while busy: ignored, with no effect on the stream. digest_valid in the same cycle as done is accepted, because the state is IDLE.
- Counter is wide enough for DIGEST_BITS/8 (or 2*DIGEST_BITS/8+2 with the feature) and never wraps.
- tx_ready is ignored when tx_valid=0.

Optional Feature:
Macro SHA_UART_HEX_ASCII_EN.
- Defined:
  - Each digest byte becomes two ASCII characters, upper nibble first.
  - Nibble 0-9 maps to 0x30-0x39; nibble a-f maps to 0x61-0x66 (lowercase).
  - After the last character, SEND_CR emits 0x0D, then SEND_LF emits 0x0A.
  - done pulses after the LF transfer.
  - Total transfers = 2*DIGEST_BITS/8 + 2 (66 for SHA-256).
  - A nibble-select bit alternates per transfer; the shift register advances only after the low-nibble transfer.
- Undefined: raw binary bytes, DIGEST_BITS/8 transfers, no terminator, and no nibble logic or extra states synthesized.

Decomposition:
- Package sha_uart_pkg holds:
  - DIGEST_BITS default
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - state encoding localparams (IDLE, SEND, SEND_CR, SEND_LF)
- One combinational sub-module, hex_nibble_to_ascii (4-bit in, 8-bit out), instantiated only under SHA_UART_HEX_ASCII_EN.

Test Plan:
- Raw mode, tx_ready=1, digest=SHA-256("abc"):
  - Input: ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Expect 32 consecutive bytes 0xBA,0x78,...,0x15,0xAD.
  - First tx_valid 1 cycle after digest_valid; done 1 cycle after the 0xAD transfer.
- Backpressure, same digest, tx_ready toggling 1-of-3 cycles: same 32-byte sequence; tx_data/tx_valid never change while tx_valid & !tx_ready.
- digest_valid pulsed mid-stream with digest=all 0xFF: ignored; output still the "abc" sequence; busy stays 1 until done.
- Reset asserted after byte 10 transferred: tx_valid=0, busy=0 immediately (async). Next digest_valid restarts from MSB byte 0xBA.
- Back-to-back: second digest_valid coincident with done: second stream starts next cycle, with no dropped or duplicated byte.
- SHA_UART_HEX_ASCII_EN, "abc" digest, tx_ready=1: 66 bytes, starting 0x62,0x61,0x37,0x38 ("ba78"), ending 0x61,0x64,0x0D,0x0A ("ad\r\n"); done after the LF.
